mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multi-cycle load/store controller sitting directly upstream of the word-addressed data memory. Accepts byte-addressed load/store requests from the datapath, drives the memory's Address/WriteData/MemWrite inputs, and consumes its combinational MemData output. Supports byte, halfword and word accesses: sign/zero-extends loads, performs read-modify-write for sub-word stores, and flags misaligned or illegal requests without touching memory.

## Interface
- ADDRESS_WIDTH, 16: word-address width presented to memory; byte address is ADDRESS_WIDTH+2 bits.
- DATA_WIDTH, 32: memory word width; only 32 is supported.
- Clk  in  1  single clock; all state changes on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Req  in  1  request strobe; sampled only when Ready=1.
- WrEn  in  1  1 = store, 0 = load.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- Unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
- ByteAddr  in  ADDRESS_WIDTH+2  byte address; [1:0] = byte offset, [ADDRESS_WIDTH+1:2] = word address.
- StoreData  in  DATA_WIDTH  store data, right-justified (byte in [7:0], half in [15:0]).
- MemData  in  DATA_WIDTH  read data from memory (combinational on Address).
- Address  out  ADDRESS_WIDTH  word address to memory.
- WriteData  out  DATA_WIDTH  write data to memory.
- MemWrite  out  1  memory write enable.
- Ready  out  1  high only in IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  valid with Done; 1 = misaligned/illegal, no access made.
- LoadData  out  DATA_WIDTH  extended load result; held until next successful load.

## Operation
- Little-endian: byte k of a word = bits [8k+7:8k].
- States: IDLE, READ, WRITE, DONE.
- IDLE: Ready=1. On Req=1 latch WrEn, Size, Unsigned, ByteAddr, StoreData; next state:
  - Err condition (Size=11; half with offset[0]=1; word with offset≠00) → DONE with Err latched 1.
  - Word store → WRITE (WriteData = StoreData).
  - Load or sub-word store → READ.
- READ: Address = latched word address. At cycle end capture MemData.
  - Load → LoadData = selected byte/half (offset-selected; half uses offset[1]) or word, extended per Unsigned; → DONE.
  - Sub-word store → merged word = MemData with target byte/half lanes replaced by StoreData[7:0]/[15:0]; → WRITE.
- WRITE: MemWrite=1, Address and WriteData stable for the whole cycle; → DONE.
- DONE: Done=1 (Err as latched); → IDLE. Err cleared on leaving DONE.
- Req ignored outside IDLE; Req held high through DONE starts a new access on the first IDLE cycle.
- Error requests never assert MemWrite and never change LoadData.

## Timing
- Cycle 0 = IDLE cycle in which Req is sampled.
- Load: READ cycle 1, Done in cycle 2; LoadData valid from cycle 2.
- Word store: WRITE cycle 1, Done cycle 2. Sub-word store: READ 1, WRITE 2, Done 3.
- Error: Done=Err=1 in cycle 1.
- Throughput: next accept no earlier than the cycle after Done.
- MemWrite, Done, Ready decoded from registered state only (glitch-free, no input-to-output paths).
- Address/WriteData held at last value outside active states; they change only on accept or READ capture.
- Reset values: state IDLE, Ready=1, Done=0, Err=0, MemWrite=0, Address=0, WriteData=0, LoadData=0.
- Rst mid-operation: all outputs take reset values immediately (asynchronously); Rst asserted during WRITE before the rising edge drops MemWrite so no write occurs; in-flight request discarded, no Done.

## Test plan
- Reset: assert Rst mid-run → Ready=1, Done=0, Err=0, MemWrite=0, Address=0, WriteData=0, LoadData=0 without waiting for Clk.
- Loads, word 4 preloaded 0x80FF7F01: LB 0x12 → 0xFFFFFFFF; LBU 0x12 → 0x000000FF; LH 0x12 → 0xFFFF80FF; LHU 0x12 → 0x000080FF; LB 0x11 → 0x0000007F; LW 0x10 → 0x80FF7F01; each Done in cycle 2, MemWrite never high.
- SB StoreData=0x000000AB at 0x11 → Address=4, MemWrite high exactly in cycle 2 with WriteData=0x80FFAB01, Done cycle 3, Err=0.
- SW 0xDEADBEEF at 0x10 → MemWrite in cycle 1 only, Done cycle 2; following LW 0x10 → LoadData=0xDEADBEEF.
- Misaligned SH at 0x13, LW at 0x12, Size=11 at 0x10 → Done=Err=1 in cycle 1, MemWrite never, memory and LoadData unchanged.
- Req held high continuously for two SH ops (0x10, 0x12; data 0x1234, 0x5678) → second accepted the cycle after first Done; final word 0x56781234.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of a word-addressed data memory.
// Handles byte/half/word access, load extension, sub-word read-modify-write and
// misalignment flagging.
module mem_access_ctrl #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32   // lane logic below assumes 32
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Req,
  input  logic                     WrEn,
  input  logic [1:0]               Size,
  input  logic                     Unsigned,
  input  logic [ADDRESS_WIDTH+1:0] ByteAddr,
  input  logic [DATA_WIDTH-1:0]    StoreData,
  input  logic [DATA_WIDTH-1:0]    MemData,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]    WriteData,
  output logic                     MemWrite,
  output logic                     Ready,
  output logic                     Done,
  output logic                     Err,
  output logic [DATA_WIDTH-1:0]    LoadData
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]               r_state;
  logic                     r_wren;
  logic                     r_uns;
  logic                     r_err;
  logic [1:0]               r_size;
  logic [1:0]               r_off;
  logic [15:0]              r_sdata;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_load;

  logic                     w_illegal;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic                     w_sign;
  logic [DATA_WIDTH-1:0]    w_load;
  logic [DATA_WIDTH-1:0]    w_merged;

  // Error decode on the live request so the decision is made in the accept cycle.
  always_comb begin
    w_illegal = 1'b0;
    case (Size)
      SZ_HALF: w_illegal = ByteAddr[0];
      SZ_WORD: w_illegal = |ByteAddr[1:0];
      SZ_BYTE: w_illegal = 1'b0;
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_byte = MemData[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? MemData[31:16] : MemData[15:0];
    w_load = MemData;
    w_sign = 1'b0;
    case (r_size)
      SZ_BYTE: begin
        w_sign = ~r_uns & w_byte[7];
        w_load = {{24{w_sign}}, w_byte};
      end
      SZ_HALF: begin
        w_sign = ~r_uns & w_half[15];
        w_load = {{16{w_sign}}, w_half};
      end
      default: w_load = MemData;
    endcase
  end

  // Sub-word store: keep untouched lanes from the current memory word.
  always_comb begin
    w_merged = MemData;
    if (r_size == SZ_BYTE)
      w_merged[{r_off, 3'b000} +: 8] = r_sdata[7:0];
    else if (r_size == SZ_HALF)
      w_merged[{r_off[1], 4'b0000} +: 16] = r_sdata;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_wren  <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'b00;
      r_off   <= 2'b00;
      r_sdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_load  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Req) begin
            r_wren  <= WrEn;
            r_size  <= Size;
            r_uns   <= Unsigned;
            r_off   <= ByteAddr[1:0];
            r_sdata <= StoreData[15:0];
            if (w_illegal) begin
              // Rejected requests leave Address/WriteData untouched.
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_addr <= ByteAddr[ADDRESS_WIDTH+1:2];
              if (WrEn && Size == SZ_WORD) begin
                r_wdata <= StoreData;
                r_state <= S_WRITE;
              end else begin
                r_state <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          if (r_wren) begin
            r_wdata <= w_merged;
            r_state <= S_WRITE;
          end else begin
            r_load  <= w_load;
            r_state <= S_DONE;
          end
        end
        S_WRITE: r_state <= S_DONE;
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Ready     = (r_state == S_IDLE);
  assign Done      = (r_state == S_DONE);
  assign MemWrite  = (r_state == S_WRITE);
  assign Err       = r_err;
  assign Address   = r_addr;
  assign WriteData = r_wdata;
  assign LoadData  = r_load;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: word memory model plus a scoreboard of
// expected completions popped on each Done.
module tb_mem_access_ctrl;

  localparam int AW = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Req;
  logic          WrEn;
  logic [1:0]    Size;
  logic          Unsigned;
  logic [AW+1:0] ByteAddr;
  logic [31:0]   StoreData;
  logic [31:0]   MemData;
  logic [AW-1:0] Address;
  logic [31:0]   WriteData;
  logic          MemWrite;
  logic          Ready;
  logic          Done;
  logic          Err;
  logic [31:0]   LoadData;

  logic [31:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          done_cyc;
    int          wr_cyc;
    logic        err;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] load;
  } exp_t;

  exp_t sb[$];

  mem_access_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .WrEn(WrEn), .Size(Size),
    .Unsigned(Unsigned), .ByteAddr(ByteAddr), .StoreData(StoreData),
    .MemData(MemData), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .Ready(Ready), .Done(Done), .Err(Err),
    .LoadData(LoadData)
  );

  always #5 Clk = ~Clk;

  assign MemData = mem[Address];
  always @(posedge Clk) if (MemWrite) mem[Address] <= WriteData;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access from accept to Done; Req dropped after the accept edge.
  task automatic run_op(input string tag, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [17:0] ba, input logic [31:0] sd,
                        input int dcyc, input int wcyc, input logic eerr,
                        input logic [31:0] ewd, input logic [31:0] eld);
    exp_t e;
    int cyc, wseen, nwr;
    logic [31:0] wd_obs;
    logic [15:0] a_obs;
    bit done;
    e = '{tag, dcyc, wcyc, eerr, ba[17:2], ewd, eld};
    sb.push_back(e);
    @(negedge Clk);
    chk($sformatf("%s ready", tag), {31'd0, Ready}, 32'd1);
    Req = 1'b1; WrEn = wr; Size = sz; Unsigned = uns; ByteAddr = ba; StoreData = sd;
    @(posedge Clk);
    cyc = 1; wseen = -1; nwr = 0; done = 0; wd_obs = '0; a_obs = '0;
    while (!done && cyc < 10) begin
      @(negedge Clk);
      if (cyc == 1) begin
        Req = 1'b0;
        a_obs = Address;
      end
      if (MemWrite) begin
        nwr++;
        if (wseen < 0) begin
          wseen = cyc;
          wd_obs = WriteData;
        end
      end
      if (Done) begin
        done = 1;
        e = sb.pop_front();
        chk($sformatf("%s done_cycle", e.tag), cyc, e.done_cyc);
        chk($sformatf("%s err", e.tag), {31'd0, Err}, {31'd0, e.err});
        chk($sformatf("%s memwrite_cycle", e.tag), wseen, e.wr_cyc);
        chk($sformatf("%s memwrite_count", e.tag), nwr, (e.wr_cyc < 0) ? 0 : 1);
        if (e.wr_cyc >= 0) chk($sformatf("%s wdata", e.tag), wd_obs, e.wdata);
        if (!e.err) chk($sformatf("%s address", e.tag), {16'd0, a_obs}, {16'd0, e.addr});
        chk($sformatf("%s loaddata", e.tag), LoadData, e.load);
      end else begin
        @(posedge Clk);
        cyc++;
      end
    end
    if (!done) chk($sformatf("%s timeout", tag), 32'd0, 32'd1);
  endtask

  initial begin
    exp_t e;
    int ndone;
    mem[4] = 32'h80FF7F01;
    mem[5] = 32'h11111111;
    Rst = 1'b1; Req = 1'b0; WrEn = 1'b0; Size = 2'b00; Unsigned = 1'b0;
    ByteAddr = '0; StoreData = '0;
    #2;
    chk("rst ready", {31'd0, Ready}, 32'd1);
    chk("rst done", {31'd0, Done}, 32'd0);
    chk("rst memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rst loaddata", LoadData, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    // Loads from word 4 = 0x80FF7F01
    run_op("LB 12",  1'b0, 2'b00, 1'b0, 18'h12, 32'h0, 2, -1, 1'b0, 32'h0, 32'hFFFFFFFF);
    run_op("LBU 12", 1'b0, 2'b00, 1'b1, 18'h12, 32'h0, 2, -1, 1'b0, 32'h0, 32'h000000FF);
    run_op("LH 12",  1'b0, 2'b01, 1'b0, 18'h12, 32'h0, 2, -1, 1'b0, 32'h0, 32'hFFFF80FF);
    run_op("LHU 12", 1'b0, 2'b01, 1'b1, 18'h12, 32'h0, 2, -1, 1'b0, 32'h0, 32'h000080FF);
    run_op("LB 11",  1'b0, 2'b00, 1'b0, 18'h11, 32'h0, 2, -1, 1'b0, 32'h0, 32'h0000007F);
    run_op("LW 10",  1'b0, 2'b10, 1'b0, 18'h10, 32'h0, 2, -1, 1'b0, 32'h0, 32'h80FF7F01);

    run_op("SB 11", 1'b1, 2'b00, 1'b0, 18'h11, 32'h000000AB, 3, 2, 1'b0, 32'h80FFAB01, 32'h80FF7F01);
    chk("SB mem", mem[4], 32'h80FFAB01);
    run_op("SW 10", 1'b1, 2'b10, 1'b0, 18'h10, 32'hDEADBEEF, 2, 1, 1'b0, 32'hDEADBEEF, 32'h80FF7F01);
    run_op("LW after SW", 1'b0, 2'b10, 1'b0, 18'h10, 32'h0, 2, -1, 1'b0, 32'h0, 32'hDEADBEEF);

    run_op("SH 13 misal",  1'b1, 2'b01, 1'b0, 18'h13, 32'h0000FFFF, 1, -1, 1'b1, 32'h0, 32'hDEADBEEF);
    run_op("LW 12 misal",  1'b0, 2'b10, 1'b0, 18'h12, 32'h0, 1, -1, 1'b1, 32'h0, 32'hDEADBEEF);
    run_op("SZ11 illegal", 1'b1, 2'b11, 1'b0, 18'h10, 32'h55555555, 1, -1, 1'b1, 32'h0, 32'hDEADBEEF);
    chk("err mem untouched", mem[4], 32'hDEADBEEF);

    // Req held high across two halfword stores; second accepted right after first Done.
    sb.push_back('{"SH 10 held", 3, 2, 1'b0, 16'd4, 32'hDEAD1234, 32'hDEADBEEF});
    sb.push_back('{"SH 12 held", 7, 6, 1'b0, 16'd4, 32'h56781234, 32'hDEADBEEF});
    @(negedge Clk);
    Req = 1'b1; WrEn = 1'b1; Size = 2'b01; Unsigned = 1'b0; ByteAddr = 18'h10; StoreData = 32'h1234;
    @(posedge Clk);
    ndone = 0;
    for (int cyc = 1; cyc < 10 && ndone < 2; cyc++) begin
      @(negedge Clk);
      if (cyc == 1) begin
        ByteAddr = 18'h12;
        StoreData = 32'h5678;
      end
      if (cyc == 4) chk("held ready c4", {31'd0, Ready}, 32'd1);
      if (MemWrite) begin
        if (sb.size() == 0) chk("held spurious write", 32'd1, 32'd0);
        else begin
          chk($sformatf("%s wr_cycle", sb[0].tag), cyc, sb[0].wr_cyc);
          chk($sformatf("%s wdata", sb[0].tag), WriteData, sb[0].wdata);
        end
      end
      if (Done) begin
        ndone++;
        if (sb.size() == 0) chk("held spurious done", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk($sformatf("%s done_cycle", e.tag), cyc, e.done_cyc);
          chk($sformatf("%s err", e.tag), {31'd0, Err}, {31'd0, e.err});
        end
        if (ndone == 2) Req = 1'b0;
      end
      @(posedge Clk);
    end
    chk("held done count", ndone, 2);
    chk("held final mem", mem[4], 32'h56781234);
    Req = 1'b0;

    // Reset while in WRITE: outputs clear at once and the write is suppressed.
    @(negedge Clk);
    Req = 1'b1; WrEn = 1'b1; Size = 2'b00; ByteAddr = 18'h15; StoreData = 32'hCC;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0;
    @(negedge Clk);
    chk("pre-rst memwrite", {31'd0, MemWrite}, 32'd1);
    Rst = 1'b1;
    #1;
    chk("mid rst ready", {31'd0, Ready}, 32'd1);
    chk("mid rst done", {31'd0, Done}, 32'd0);
    chk("mid rst err", {31'd0, Err}, 32'd0);
    chk("mid rst memwrite", {31'd0, MemWrite}, 32'd0);
    chk("mid rst address", {16'd0, Address}, 32'd0);
    chk("mid rst wdata", WriteData, 32'd0);
    chk("mid rst loaddata", LoadData, 32'd0);
    @(posedge Clk);
    #1;
    chk("rst no write", mem[5], 32'h11111111);
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("post rst no done", {31'd0, Done}, 32'd0);
    end
    chk("scoreboard empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
